// File: rtl/control_unit_pipelined.sv
// control_unit_pipelined: ID-stage decoder for the pipelined RV32 core with
// an ID/EX control register and a mul/div sequencer.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   instrD             - instruction in ID
//   flushE             - turns the next ID/EX capture into a bubble
//   ImmSrcD            - immediate format (combinational from instrD)
//   *E outputs         - registered ID/EX control fields
//   mdStartE           - one-cycle pulse on the first EX cycle of an M op
//   illegalE           - instruction in EX is illegal (travels as a NOP)
//   stallMD            - mul/div busy, front end must hold while high
module control_unit_pipelined #(
    parameter bit          ENABLE_M    = 1'b1,
    parameter int unsigned MUL_LATENCY = 1,
    parameter int unsigned DIV_LATENCY = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrD,
    input  logic        flushE,
    output logic [2:0]  ImmSrcD,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        ALUSrcE,
    output logic        ALUSrcAE,
    output logic        branchE,
    output logic        jumpE,
    output logic        jalrE,
    output logic [1:0]  ResultSrcE,
    output logic [4:0]  ALUControlE,
    output logic [2:0]  AddressingControlE,
    output logic        mdStartE,
    output logic        illegalE,
    output logic        stallMD
);

    localparam int unsigned MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_CNT   = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_CNT   = CNT_W'(DIV_LATENCY - 1);
    localparam bit               MUL_MULTI = (MUL_LATENCY > 32'd1);
    localparam bit               DIV_MULTI = (DIV_LATENCY > 32'd1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b00101;
    localparam logic [4:0] ALU_SLTU = 5'b00110;
    localparam logic [4:0] ALU_SLL  = 5'b00111;
    localparam logic [4:0] ALU_SRL  = 5'b01000;
    localparam logic [4:0] ALU_BGE  = 5'b01001;
    localparam logic [4:0] ALU_BGEU = 5'b01010;
    localparam logic [4:0] ALU_SRA  = 5'b01011;
    localparam logic [4:0] ALU_BNE  = 5'b01100;
    localparam logic [4:0] ALU_LUI  = 5'b01111;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       alu_src_a;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [1:0] result_src;
        logic [4:0] alu_control;
        logic [2:0] addr_ctrl;
        logic       md_start;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr;

    assign opcode       = instrD[6:0];
    assign funct3       = instrD[14:12];
    assign funct7       = instrD[31:25];
    assign unused_instr = ^{instrD[24:15], instrD[11:7]};

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    ctrl_t            ctrl_q;
    ctrl_t            ctrl_d;
    logic [2:0]       imm_src_d;
    logic             md_op_d;
    logic             md_long_d;
    logic [CNT_W-1:0] md_cnt_d;
    logic             bad_d;

    // funct3 -> ALU op shared by R-type (funct7=0) and OP-IMM
    function automatic logic [4:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    // Instruction decode and legality check
    always_comb begin
        ctrl_d    = '0;
        imm_src_d = IMM_I;
        md_op_d   = 1'b0;
        bad_d     = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl_d.reg_write = 1'b1;
                case (funct7)
                    F7_BASE: ctrl_d.alu_control = base_alu(funct3);
                    F7_ALT: begin
                        if (funct3 == 3'b000)      ctrl_d.alu_control = ALU_SUB;
                        else if (funct3 == 3'b101) ctrl_d.alu_control = ALU_SRA;
                        else                       bad_d = 1'b1;
                    end
                    F7_MULDIV: begin
                        if (ENABLE_M) begin
                            ctrl_d.alu_control = {2'b10, funct3};
                            md_op_d            = 1'b1;
                        end else begin
                            bad_d = 1'b1;
                        end
                    end
                    default: bad_d = 1'b1;
                endcase
            end
            OP_IMM: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = base_alu(funct3);
                if (funct3 == 3'b001 && funct7 != F7_BASE) bad_d = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)       ctrl_d.alu_control = ALU_SRA;
                    else if (funct7 != F7_BASE) bad_d = 1'b1;
                end
            end
            OP_LOAD: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = 2'b01;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.addr_ctrl  = funct3;
                if (!(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) bad_d = 1'b1;
            end
            OP_STORE: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.addr_ctrl = funct3;
                imm_src_d        = IMM_S;
                if (!(funct3 inside {3'b000, 3'b001, 3'b010})) bad_d = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_d.branch = 1'b1;
                imm_src_d     = IMM_B;
                case (funct3)
                    3'b000:  ctrl_d.alu_control = ALU_SUB;
                    3'b001:  ctrl_d.alu_control = ALU_BNE;
                    3'b100:  ctrl_d.alu_control = ALU_SLT;
                    3'b101:  ctrl_d.alu_control = ALU_BGE;
                    3'b110:  ctrl_d.alu_control = ALU_SLTU;
                    3'b111:  ctrl_d.alu_control = ALU_BGEU;
                    default: bad_d = 1'b1;
                endcase
            end
            OP_JAL: begin
                ctrl_d.jump       = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = 2'b10;
                imm_src_d         = IMM_J;
            end
            OP_JALR: begin
                ctrl_d.jump       = 1'b1;
                ctrl_d.jalr       = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.result_src = 2'b10;
                if (funct3 != 3'b000) bad_d = 1'b1;
            end
            OP_LUI: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = ALU_LUI;
                imm_src_d          = IMM_U;
            end
            OP_AUIPC: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                imm_src_d        = IMM_U;
            end
            default: bad_d = 1'b1;
        endcase
        // Illegal instructions travel down the pipe as a flagged NOP
        if (bad_d) begin
            ctrl_d         = '0;
            ctrl_d.illegal = 1'b1;
            md_op_d        = 1'b0;
        end
        ctrl_d.md_start = md_op_d;
    end

    // funct3[2] separates the divide group from the multiply group
    assign md_long_d = md_op_d && (funct3[2] ? DIV_MULTI : MUL_MULTI);
    assign md_cnt_d  = funct3[2] ? DIV_CNT : MUL_CNT;

    // ID/EX register and mul/div sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else if (flushE) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else if (state_q == BUSY) begin
            ctrl_q.md_start <= 1'b0;
            cnt_q           <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= IDLE;
        end else begin
            ctrl_q <= ctrl_d;
            if (md_long_d) begin
                state_q <= BUSY;
                cnt_q   <= md_cnt_d;
            end
        end
    end

    assign ImmSrcD            = imm_src_d;
    assign stallMD            = (state_q == BUSY);
    assign RegWriteE          = ctrl_q.reg_write;
    assign MemWriteE          = ctrl_q.mem_write;
    assign ALUSrcE            = ctrl_q.alu_src;
    assign ALUSrcAE           = ctrl_q.alu_src_a;
    assign branchE            = ctrl_q.branch;
    assign jumpE              = ctrl_q.jump;
    assign jalrE              = ctrl_q.jalr;
    assign ResultSrcE         = ctrl_q.result_src;
    assign ALUControlE        = ctrl_q.alu_control;
    assign AddressingControlE = ctrl_q.addr_ctrl;
    assign mdStartE           = ctrl_q.md_start;
    assign illegalE           = ctrl_q.illegal;

endmodule

// File: doc/control_unit_pipelined.md
# control_unit_pipelined

Registered decode/control block for the pipelined RV32 core. Decodes the instruction in ID, generates all control fields, and holds them in the ID/EX control register. It extends base RV32I decode with AUIPC, strict illegal-instruction detection and an optional M extension. A multi-cycle mul/div sequencer stalls the front end while a long-latency M op occupies EX.

## Interface
Parameters:
- ENABLE_M, 1: 1 decodes M-extension ops; 0 flags them illegal.
- MUL_LATENCY, 1: EX cycles taken by MUL/MULH/MULHSU/MULHU. Must be at least 1.
- DIV_LATENCY, 33: EX cycles taken by DIV/DIVU/REM/REMU. Must be at least 1.

Ports:
- clk  in  1: clock.
- rst  in  1: reset. Asynchronous, active-high.
- instrD  in  32: instruction in ID.
- flushE  in  1: converts the next ID/EX capture into a bubble. The hazard unit asserts it together with its own stallD for load-use stalls.
- ImmSrcD  out  3: combinational. Encodings: I=000, S=001, B=010, J=011, U=100.
- RegWriteE, MemWriteE, ALUSrcE, ALUSrcAE, branchE, jumpE, jalrE  out  1 each: registered control bits. ALUSrcAE=1 selects PC as ALU operand A.
- ResultSrcE  out  2: 00 ALU, 01 memory, 10 PC+4.
- ALUControlE  out  5: registered ALU operation.
- AddressingControlE  out  3: funct3 for loads and stores, otherwise 0.
- mdStartE  out  1: one-cycle pulse on the first EX cycle of an M op.
- illegalE  out  1: instruction in EX is illegal.
- stallMD  out  1: mul/div busy. The hazard unit must hold PC, IF/ID and ID/EX while this is high.

## Operation
ALUControl encodings (5 bits):
- Base ops: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLT 00101, SLTU 00110, SLL 00111, SRL 01000, SRA 01011, LUI 01111.
- Branch compares: BGE 01001, BGEU 01010, BNE 01100.
- M ops: MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.

Decode by opcode:
- R-type (0110011): RegWrite=1.
  - funct7=0000000 selects base ops.
  - funct7=0100000 is legal only for SUB (funct3 000) and SRA (funct3 101).
  - funct7=0000001 selects M ops when ENABLE_M=1.
  - Any other funct7/funct3 combination is illegal.
- OP-IMM (0010011): ALUSrc=1, ImmSrc I. SLLI requires funct7=0000000; SRLI/SRAI require funct7 0000000 or 0100000; otherwise illegal.
- Load (0000011): ResultSrc=01, ALUSrc=1. funct3 must be in {000,001,010,100,101}.
- Store (0100011): MemWrite=1, ALUSrc=1, ImmSrc S. funct3 must be in {000,001,010}.
- Branch (1100011): branchD=1, ImmSrc B.
  - funct3 maps as: 000 SUB, 001 BNE, 100 SLT, 101 BGE, 110 SLTU, 111 BGEU.
  - funct3 010 and 011 are illegal.
- JAL (1101111): jump=1, ResultSrc=10, ImmSrc J.
- JALR (1100111): jump=1, jalr=1, ALUSrc=1, ResultSrc=10. funct3 must be 000.
- LUI (0110111): ALUSrc=1, ImmSrc U, ALUControl LUI.
- AUIPC (0010111): ALUSrcA=1, ALUSrc=1, ImmSrc U, ALUControl ADD, RegWrite=1.
- Any other opcode is illegal.

Illegal instructions:
- Set illegal=1 and force RegWrite, MemWrite, branch and jump to 0, so the instruction travels as a NOP.
- ImmSrcD is don't-care.

Sequencer FSM, states IDLE and BUSY, counter width $clog2(max(MUL_LATENCY,DIV_LATENCY)+1):
- IDLE, flushE=0, decoded M op, selected latency L>1: capture into ID/EX, set mdStartE=1, go to BUSY with cnt=L-1.
- IDLE, L=1 or non-M op: capture normally and stay IDLE.
- BUSY: stallMD=1, ID/EX holds unchanged, cnt decrements each cycle. When cnt==1, next state is IDLE.
- flushE has priority over everything except rst. It zeroes ID/EX and forces IDLE, aborting any M op in progress.
- Result: an M op occupies EX for exactly L cycles, and stallMD is high for L-1 cycles.

## Timing
- Reset (async, any cycle, including mid-BUSY): every registered output is 0, state is IDLE, cnt is 0, stallMD is 0.
- Decode-to-EX latency is 1 cycle. ImmSrcD and stallMD are combinational, from instrD and the state respectively.
- mdStartE is high only in the capture cycle's EX. It is low throughout BUSY.
- Priority each cycle: rst, then flushE, then BUSY hold, then normal capture.
- A back-to-back M op in ID while BUSY waits. It is captured in the cycle after BUSY ends, with a fresh mdStartE.

## Test plan
- Reset mid-DIV: DIV in BUSY with cnt=20, pulse rst. Then all E outputs are 0, stallMD=0, state is IDLE immediately (asynchronous).
- Base decode:
  - 0x002081B3 (add) -> RegWriteE=1, ALUControlE=00000.
  - 0x402081B3 (sub) -> ALUControlE=00001.
  - 0x00208063 (beq) -> branchE=1, ALUControlE=00001, ImmSrcD=010.
  - 0x00001297 (auipc) -> ALUSrcAE=1, ALUSrcE=1, ImmSrcD=100.
- Illegal:
  - 0xFFFFFFFF -> illegalE=1, RegWriteE=0, MemWriteE=0.
  - 0x602081B3 (bad funct7) -> illegalE=1.
  - With ENABLE_M=0, 0x022081B3 -> illegalE=1.
- MUL with MUL_LATENCY=1: 0x022081B3 -> ALUControlE=10000, mdStartE pulses for 1 cycle, stallMD never asserts.
- DIV with DIV_LATENCY=33: 0x0220C1B3 -> ALUControlE=10100, stallMD high for exactly 32 cycles, ID/EX stable throughout. A following add is captured on cycle 33.
- flushE during BUSY (cnt=10) -> next cycle ID/EX is zero, stallMD=0, state is IDLE.
